// File: rtl/median_sorter.sv
// Rank-order stage for the adaptive median filter: loads one pixel window, sorts it
// in place with an odd-even transposition network and presents z_min/z_med/z_max/z_xy.

module comparator #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  y
);
    // y flags b > a; equal values never request a swap.
    assign y = (b > a);
endmodule

module median_sorter #(
    parameter int DATA_WIDTH = 8,
    parameter int WINDOW     = 9
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_WIDTH*WINDOW-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        z_min,
    output logic [DATA_WIDTH-1:0]        z_med,
    output logic [DATA_WIDTH-1:0]        z_max,
    output logic [DATA_WIDTH-1:0]        z_xy
);
    localparam int MID     = (WINDOW - 1) / 2;
    localparam int PHASE_W = $clog2(WINDOW + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SORT,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [DATA_WIDTH-1:0] r_data      [WINDOW];
    logic [DATA_WIDTH-1:0] w_data_next [WINDOW];
    logic [DATA_WIDTH-1:0] r_centre;
    logic [PHASE_W-1:0]    r_phase;
    logic [WINDOW-2:0]     w_gt;
    logic                  w_load;
    logic                  w_step;

    // One comparator per adjacent pair; the phase parity decides which ones act.
    for (genvar g = 0; g < WINDOW - 1; g++) begin : g_cmp
        comparator #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_cmp (
            .a(r_data[g+1]),
            .b(r_data[g]),
            .y(w_gt[g])
        );
    end

    always_comb begin
        for (int i = 0; i < WINDOW; i++) begin
            w_data_next[i] = r_data[i];
        end
        for (int i = 0; i < WINDOW - 1; i++) begin
            if ((i[0] == r_phase[0]) && w_gt[i]) begin
                w_data_next[i]   = r_data[i+1];
                w_data_next[i+1] = r_data[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every control output gets a default before the case so no path infers a latch.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                in_ready = !rst;
                if (in_valid && !rst) begin
                    w_load       = 1'b1;
                    w_state_next = S_SORT;
                end
            end
            S_SORT: begin
                w_step = 1'b1;
                if (r_phase == PHASE_W'(WINDOW - 1)) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // NOTE: the sort registers are reset (not left as plain storage) because z_* must read 0 out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WINDOW; i++) begin
                r_data[i] <= '0;
            end
            r_centre <= '0;
            r_phase  <= '0;
        end else if (w_load) begin
            for (int i = 0; i < WINDOW; i++) begin
                r_data[i] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
            r_centre <= in_data[MID*DATA_WIDTH +: DATA_WIDTH];
            r_phase  <= '0;
        end else if (w_step) begin
            for (int i = 0; i < WINDOW; i++) begin
                r_data[i] <= w_data_next[i];
            end
            r_phase <= r_phase + PHASE_W'(1);
        end
    end

    assign z_min = r_data[0];
    assign z_med = r_data[MID];
    assign z_max = r_data[WINDOW-1];
    assign z_xy  = r_centre;

endmodule

// File: tb/tb_median_sorter.sv
// Self-checking bench for median_sorter: directed vector table, backpressure and reset
// sequences, and back-to-back random windows against a queue-sort reference.

module tb_median_sorter;
    localparam int DW  = 8;
    localparam int W   = 9;
    localparam int MID = (W - 1) / 2;

    typedef struct packed {
        logic [DW-1:0] mn;
        logic [DW-1:0] md;
        logic [DW-1:0] mx;
        logic [DW-1:0] xy;
    } exp_t;

    typedef struct {
        logic [DW*W-1:0] data;
        exp_t            e;
        bit              each_phase;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [DW*W-1:0] in_data = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [DW-1:0]   z_min, z_med, z_max, z_xy;

    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    median_sorter #(
        .DATA_WIDTH(DW),
        .WINDOW    (W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .z_min    (z_min),
        .z_med    (z_med),
        .z_max    (z_max),
        .z_xy     (z_xy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    function automatic logic [DW*W-1:0] mk(input int a0, input int a1, input int a2,
                                           input int a3, input int a4, input int a5,
                                           input int a6, input int a7, input int a8);
        return {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    endfunction

    // Reference: sort a copy of the window and pick ranks; centre is the unsorted middle pixel.
    function automatic exp_t model(input logic [DW*W-1:0] d);
        int   q[$];
        exp_t e;
        for (int i = 0; i < W; i++) q.push_back(int'(d[i*DW +: DW]));
        q.sort();
        e.mn = 8'(q[0]);
        e.md = 8'(q[MID]);
        e.mx = 8'(q[W-1]);
        e.xy = d[MID*DW +: DW];
        return e;
    endfunction

    task automatic check_z(input string tag, input exp_t e);
        check({tag, "_min"}, 32'(z_min), 32'(e.mn));
        check({tag, "_med"}, 32'(z_med), 32'(e.md));
        check({tag, "_max"}, 32'(z_max), 32'(e.mx));
        check({tag, "_xy"},  32'(z_xy),  32'(e.xy));
    endtask

    // Present a window and wait for the accept edge; returns its cycle number.
    task automatic accept(input logic [DW*W-1:0] d, input string tag, output int t_acc);
        bit seen = 1'b0;
        in_data  = d;
        in_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (in_ready) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_accept_seen"}, 32'(seen), 32'd1);
        t_acc = int'(cyc) + 1;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = ~d;
    endtask

    task automatic run_window(input logic [DW*W-1:0] d, input exp_t e, input string tag,
                              input bit each_phase);
        int t_acc;
        bit seen = 1'b0;
        int bad  = 0;
        accept(d, tag, t_acc);
        for (int c = 0; c < 30; c++) begin
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            if (each_phase && ({z_min, z_med, z_max, z_xy} != e)) bad++;
            @(negedge clk);
        end
        check({tag, "_result_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, 32'(int'(cyc) - t_acc), 32'd9);
        if (each_phase) check({tag, "_phase_changes"}, 32'(bad), 32'd0);
        check_z(tag, e);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_ov_after_hs"}, 32'(out_valid), 32'd0);
        check({tag, "_rdy_after_hs"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        vec_t            vecs[5];
        logic [DW*W-1:0] d;
        exp_t            e;
        int              t_acc;
        int              bad;
        int              cnt;
        bit              seen;
        logic [DW*W-1:0] wins[$];
        exp_t            exps[$];
        int              acc[$];
        int              k;
        int              got;
        localparam int   N = 20;

        vecs[0] = '{mk(9, 8, 7, 6, 5, 4, 3, 2, 1), '{8'd1, 8'd5, 8'd9, 8'd5}, 1'b0};
        vecs[1] = '{mk(255, 0, 255, 0, 128, 0, 255, 0, 255), '{8'd0, 8'd128, 8'd255, 8'd128}, 1'b0};
        vecs[2] = '{mk(128, 128, 128, 128, 128, 128, 128, 128, 128), '{8'h80, 8'h80, 8'h80, 8'h80}, 1'b1};
        vecs[3] = '{mk(7, 7, 7, 200, 1, 7, 7, 7, 7), '{8'd1, 8'd7, 8'd200, 8'd1}, 1'b0};
        vecs[4] = '{mk(0, 0, 0, 0, 255, 0, 0, 0, 0), '{8'd0, 8'd0, 8'd255, 8'd255}, 1'b0};

        // Reset state
        #1 rst = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check_z("rst", '0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel_in_ready", 32'(in_ready), 32'd1);

        // Directed vector table
        for (int v = 0; v < 5; v++) begin
            run_window(vecs[v].data, vecs[v].e, $sformatf("vec%0d", v), vecs[v].each_phase);
        end

        // Backpressure with a second window held on the input
        d = mk(3, 1, 4, 1, 5, 9, 2, 6, 5);
        e = '{8'd1, 8'd4, 8'd9, 8'd5};
        accept(d, "bp", t_acc);
        in_data  = mk(200, 201, 202, 203, 204, 205, 206, 207, 208);
        in_valid = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("bp_result_seen", 32'(seen), 32'd1);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            if (!out_valid || in_ready || ({z_min, z_med, z_max, z_xy} != e)) bad++;
            @(negedge clk);
        end
        check("bp_stable_cycles", 32'(bad), 32'd0);
        check_z("bp", e);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("bp_ov_after_hs", 32'(out_valid), 32'd0);
        check("bp_rdy_after_hs", 32'(in_ready), 32'd1);
        cnt = 0;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (out_valid) cnt++;
            if (!in_ready || z_med != e.md) bad++;
        end
        check("bp_extra_hs", 32'(cnt), 32'd0);
        check("bp_held_not_taken", 32'(bad), 32'd0);

        // Reset while phase 3 is pending
        accept(mk(11, 22, 33, 44, 55, 66, 77, 88, 99), "rs", t_acc);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rs_out_valid", 32'(out_valid), 32'd0);
        check("rs_in_ready", 32'(in_ready), 32'd0);
        check_z("rs", '0);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int c = 0; c < 15; c++) begin
            if (out_valid) cnt++;
            @(negedge clk);
        end
        check("rs_no_result", 32'(cnt), 32'd0);
        run_window(mk(10, 20, 30, 40, 50, 60, 70, 80, 90), '{8'd10, 8'd50, 8'd90, 8'd50}, "post_rs", 1'b0);

        // Back-to-back random windows, in_valid and out_ready held high
        for (int j = 0; j < N; j++) begin
            for (int i = 0; i < W; i++) begin
                d[i*DW +: DW] = (j % 3 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
            end
            wins.push_back(d);
            exps.push_back(model(d));
        end
        k   = 0;
        got = 0;
        out_ready = 1'b1;
        for (int c = 0; c < N * (W + 2) + 40 && got < N; c++) begin
            in_valid = (k < N);
            in_data  = (k < N) ? wins[k] : '0;
            if (in_valid && in_ready) begin
                acc.push_back(int'(cyc) + 1);
                k++;
            end
            if (out_valid) begin
                check_z($sformatf("b2b%0d", got), exps[got]);
                got++;
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b_results", 32'(got), 32'(N));
        for (int j = 1; j < acc.size(); j++) begin
            check($sformatf("b2b_spacing%0d", j), 32'(acc[j] - acc[j-1]), 32'd11);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
